// File: rtl/dac_serial_frame_rx.sv
// Receiver for the three-wire serial DAC link (sync / sclk / din): frames on SYNC, shifts DIN on SCLK falls.
// Latency: frame_valid rises 4 clk cycles after the pin-level final SCLK falling edge.
// Backpressure: none; the link is receive-only and each committed frame overwrites the previous one.
//
// Ports:
//   clk, rst_n                  system clock (>= 4x SCLK rate), asynchronous active-low reset
//   sclk_in, sync_in, din_in    asynchronous link pins; sync is an active-low frame strobe, din is MSB first
//   frame_word                  last complete frame
//   data_out, pd_mode           data field frame_word[DATA_W-1:0] and power-down field frame_word[PD_LSB+1:PD_LSB]
//   frame_valid, frame_err      one-cycle pulses: frame committed / frame aborted early
//   busy                        high while a frame is being shifted in or SYNC is still low after it
//   frame_cnt, err_cnt          wrapping 16-bit event counters, present only when DAC_RX_FRAME_CNT_EN is defined
//
// Optional feature macro: DAC_RX_FRAME_CNT_EN (adds frame_cnt / err_cnt).

module dac_serial_frame_rx #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12,
    parameter int PD_LSB     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk_in,
    input  logic                  sync_in,
    input  logic                  din_in,
    output logic [FRAME_BITS-1:0] frame_word,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            pd_mode,
    output logic                  frame_valid,
    output logic                  frame_err,
`ifdef DAC_RX_FRAME_CNT_EN
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt,
`endif
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_HI = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    logic                  commit_pend, commit_nx;
    logic                  err_nx;

    // Synchronizer chains: [0] first stage, [1] synchronized value, [2] previous
    // synchronized value for edge detection. din needs no edge detection, so its
    // chain stops at the synchronized stage.
    logic [2:0] sclk_sr;
    logic [2:0] sync_sr;
    logic [1:0] din_sr;

    // The chains come out of reset holding idle values rather than real pin
    // samples. Edges are only trusted once three clocks have refilled the chain;
    // otherwise SYNC already low at reset release would look like a fresh
    // sync_fall and a frame in progress would be picked up half way through.
    logic [1:0] warm_cnt;
    logic       warm;

    logic sclk_fall;
    logic sync_fall;
    logic sync_rise;
    logic din_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr  <= 3'b111;
            sync_sr  <= 3'b111;
            din_sr   <= 2'b00;
            warm_cnt <= 2'd0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk_in};
            sync_sr <= {sync_sr[1:0], sync_in};
            din_sr  <= {din_sr[0], din_in};
            if (!warm) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign warm      = (warm_cnt == 2'd3);
    assign sclk_fall = warm &  sclk_sr[2] & ~sclk_sr[1];
    assign sync_fall = warm &  sync_sr[2] & ~sync_sr[1];
    assign sync_rise = warm & ~sync_sr[2] &  sync_sr[1];
    assign din_s     = din_sr[1];

    // Next-state logic.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        commit_nx  = 1'b0;
        err_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (sync_fall) begin
                    state_nx   = SHIFT;
                    bit_cnt_nx = '0;
                end
            end

            SHIFT: begin
                if (sclk_fall && (bit_cnt == LAST_BIT)) begin
                    // Final bit wins over a coincident sync_rise: the frame is
                    // complete, so it commits. If SYNC already rose there is no
                    // later rise to wait for, so go straight back to IDLE.
                    shreg_nx   = {shreg[FRAME_BITS-2:0], din_s};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    commit_nx  = 1'b1;
                    state_nx   = sync_rise ? IDLE : WAIT_HI;
                end else if (sync_rise) begin
                    // Short frame; a coincident non-final sclk edge is dropped.
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (sclk_fall) begin
                    shreg_nx   = {shreg[FRAME_BITS-2:0], din_s};
                    bit_cnt_nx = bit_cnt + 1'b1;
                end
            end

            WAIT_HI: begin
                // Surplus SCLK edges inside the same SYNC window are ignored.
                if (sync_rise) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, shifter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            shreg       <= shreg_nx;
            commit_pend <= commit_nx;
            frame_err   <= err_nx;
            busy        <= (state_nx != IDLE);
        end
    end

    // Commit register: the shifter is stable for the cycle after the final
    // edge (no shifting in WAIT_HI / IDLE), so the frame is copied out here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_word  <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit_pend;
            if (commit_pend) begin
                frame_word <= shreg;
            end
        end
    end

    assign data_out = frame_word[DATA_W-1:0];
    assign pd_mode  = frame_word[PD_LSB+1:PD_LSB];

`ifdef DAC_RX_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (frame_valid) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (frame_err) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dac_serial_frame_rx.sv
// Bench for dac_serial_frame_rx: drives the serial link pins, predicts the frame
// events from the number of SCLK falls inside each SYNC-low window, and checks
// every output each clock against that prediction.

module tb_dac_serial_frame_rx;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sclk_in = 1'b1;
    logic        sync_in = 1'b1;
    logic        din_in  = 1'b0;
    logic [15:0] frame_word;
    logic [11:0] data_out;
    logic [1:0]  pd_mode;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;
`ifdef DAC_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    int          n_valid_model = 0;
    int          n_err_model   = 0;
`endif

    dac_serial_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_in     (sclk_in),
        .sync_in     (sync_in),
        .din_in      (din_in),
        .frame_word  (frame_word),
        .data_out    (data_out),
        .pd_mode     (pd_mode),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef DAC_RX_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
`endif
        .busy        (busy)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fall16_cyc = 0;
    int rise_cyc   = 0;
    bit busy_pend  = 1'b0;

    // Model state: expected events in order ({is_err, word}) and the word the
    // outputs must currently show.
    logic [16:0] evq[$];
    logic [15:0] exp_word = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 10 ns after a falling clk edge, well away from the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #10;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [16:0] ev;
        cyc++;
        if (!rst_n) begin
            exp_word = 16'h0;
            evq.delete();
            busy_pend = 1'b0;
            chk("rst_frame_word", {16'h0, frame_word}, 32'h0);
            chk("rst_valid", {31'h0, frame_valid}, 32'h0);
            chk("rst_err", {31'h0, frame_err}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
        end else begin
            if (frame_valid) begin
                if (evq.size() == 0 || evq[0][16]) begin
                    chk("unexpected_valid", {31'h0, frame_valid}, 32'h0);
                end else begin
                    ev = evq.pop_front();
                    exp_word = ev[15:0];
                    chk("valid_latency", cyc - fall16_cyc, 32'd4);
                end
            end
            if (frame_err) begin
                if (evq.size() == 0 || !evq[0][16]) begin
                    chk("unexpected_err", {31'h0, frame_err}, 32'h0);
                end else begin
                    ev = evq.pop_front();
                    chk("err_no_valid", {31'h0, frame_valid}, 32'h0);
                end
            end
            if (busy_pend && !busy) begin
                chk("busy_drop_latency", cyc - rise_cyc, 32'd3);
                busy_pend = 1'b0;
            end
            chk("frame_word", {16'h0, frame_word}, {16'h0, exp_word});
            chk("data_out", {20'h0, data_out}, {20'h0, exp_word[11:0]});
            chk("pd_mode", {30'h0, pd_mode}, {30'h0, exp_word[13:12]});
        end
    end

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (evq.size() == 0 && !busy_pend) break;
            tick(1);
        end
        chk("events_drained", evq.size(), 32'd0);
        chk("busy_dropped", {31'h0, busy_pend}, 32'h0);
    endtask

    // One SYNC-low window with nf SCLK falls; bits[31] is sent first.
    // simul=1 raises SYNC on the same instant as the last SCLK fall.
    // A frame commits exactly when at least 16 falls are accepted. The coincident
    // final fall is accepted only when it is the 16th; any other coincident fall
    // lands on a short frame (still an error) or in the surplus (still a commit),
    // so the outcome reduces to nf >= 16.
    task automatic send_frame(input logic [31:0] bits, input int nf, input bit simul);
        if (nf >= 16) begin
            evq.push_back({1'b0, bits[31:16]});
`ifdef DAC_RX_FRAME_CNT_EN
            n_valid_model++;
`endif
        end else begin
            evq.push_back({1'b1, 16'h0});
`ifdef DAC_RX_FRAME_CNT_EN
            n_err_model++;
`endif
        end
        sync_in = 1'b0;
        tick(2);
        for (int i = 0; i < nf; i++) begin
            din_in  = bits[31-i];
            sclk_in = 1'b1;
            tick(2);
            sclk_in = 1'b0;
            if (i == 15) fall16_cyc = cyc;
            if (simul && i == nf - 1) begin
                sync_in   = 1'b1;
                rise_cyc  = cyc;
                busy_pend = 1'b1;
            end
            tick(2);
        end
        sclk_in = 1'b1;
        if (!simul) begin
            tick(2);
            sync_in   = 1'b1;
            rise_cyc  = cyc;
            busy_pend = 1'b1;
        end
        tick(8);
        drain();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rbits;
        int          rnf;
        bit          rsim;

        rst_n = 1'b0;
        tick(1);
        chk("reset_data_out", {20'h0, data_out}, 32'h0);
        chk("reset_pd_mode", {30'h0, pd_mode}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Single frame, hand-computed fields.
        send_frame({16'h2ABC, 16'h0}, 16, 1'b0);
        chk("single_word", {16'h0, frame_word}, 32'h2ABC);
        chk("single_pd", {30'h0, pd_mode}, 32'h2);
        chk("single_data", {20'h0, data_out}, 32'hABC);

        // Back-to-back with two SCLK periods of SYNC high between.
        send_frame({16'h0FFF, 16'h0}, 16, 1'b0);
        chk("b2b_data_1", {20'h0, data_out}, 32'hFFF);
        send_frame({16'h0001, 16'h0}, 16, 1'b0);
        chk("b2b_data_2", {20'h0, data_out}, 32'h001);

        // Early abort after 9 bits keeps the previous word.
        send_frame({16'h1234, 16'h0}, 9, 1'b0);
        chk("abort_keeps_word", {16'h0, frame_word}, 32'h0001);
        send_frame({16'h0555, 16'h0}, 16, 1'b0);
        chk("after_abort_word", {16'h0, frame_word}, 32'h0555);

        // Surplus SCLK falls inside one SYNC window.
        send_frame({16'h3001, 16'hA5A5}, 20, 1'b0);
        chk("extra_clk_word", {16'h0, frame_word}, 32'h3001);

        // SYNC rising together with the final / a non-final SCLK fall.
        send_frame({16'h4321, 16'h0}, 16, 1'b1);
        chk("simul_final_word", {16'h0, frame_word}, 32'h4321);
        send_frame({16'h7777, 16'h0}, 10, 1'b1);
        chk("simul_abort_word", {16'h0, frame_word}, 32'h4321);

        // Reset in the middle of a frame; the remainder must be ignored.
        sync_in = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            din_in  = 1'b1;
            sclk_in = 1'b1;
            tick(2);
            sclk_in = 1'b0;
            tick(2);
        end
        sclk_in = 1'b1;
        tick(2);
        sync_in = 1'b1;
        tick(8);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_word", {16'h0, frame_word}, 32'h0);
`ifdef DAC_RX_FRAME_CNT_EN
        n_valid_model = 0;
        n_err_model   = 0;
        chk("midrst_frame_cnt", {16'h0, frame_cnt}, 32'd0);
        send_frame({16'h1111, 16'h0}, 16, 1'b0);
        send_frame({16'h2222, 16'h0}, 16, 1'b0);
        send_frame({16'h3333, 16'h0}, 16, 1'b0);
        send_frame({16'h4444, 16'h0}, 5, 1'b0);
        chk("cnt_frames", {16'h0, frame_cnt}, 32'd3);
        chk("cnt_errs", {16'h0, err_cnt}, 32'd1);
`endif

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            rbits = $urandom;
            if ($urandom_range(9, 0) < 7) rnf = $urandom_range(20, 16);
            else                          rnf = $urandom_range(15, 1);
            rsim = ($urandom_range(3, 0) == 0);
            send_frame(rbits, rnf, rsim);
        end
`ifdef DAC_RX_FRAME_CNT_EN
        chk("cnt_frames_final", {16'h0, frame_cnt}, n_valid_model);
        chk("cnt_errs_final", {16'h0, err_cnt}, n_err_model);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_serial_frame_rx.md
Name: dac_serial_frame_rx

Overview:
- Receiving end of the three-wire serial DAC link (sync / clk_out / din) driven by the existing DAC driver in `main`.
- Oversamples the link on the system clock, frames on SYNC, and shifts DIN on SCLK falling edges, matching DAC input-register timing.
- Delivers each completed frame as a parallel word with decoded power-down and data fields.
- Used for loopback self-check and as a synthesizable DAC model; one instance per DAC channel.

Parameters:
- FRAME_BITS, 16: SCLK falling edges per valid frame.
- DATA_W, 12: width of the data field, frame bits [DATA_W-1:0].
- PD_LSB, 12: LSB position of the 2-bit power-down field, frame bits [PD_LSB+1:PD_LSB].

Ports:
- clk  in  1  system clock; frequency must be at least 4x the SCLK rate.
- rst_n  in  1  asynchronous active-low reset.
- sclk_in  in  1  serial clock from the driver's clk_out (asynchronous).
- sync_in  in  1  active-low frame strobe from the driver's sync (asynchronous).
- din_in  in  1  serial data, MSB first (asynchronous).
- frame_word  out  FRAME_BITS  last complete frame.
- data_out  out  DATA_W  frame_word[DATA_W-1:0].
- pd_mode  out  2  frame_word[PD_LSB+1:PD_LSB].
- frame_valid  out  1  one-cycle pulse when a new frame is committed.
- frame_err  out  1  one-cycle pulse when a frame is aborted early.
- busy  out  1  high while in SHIFT or WAIT_HI.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: frame_word=0, data_out=0, pd_mode=0, frame_valid=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, shift register=0.
- Synchronizers: sclk_in, sync_in and din_in each pass through a 2-FF synchronizer. A third register per signal supports edge detection.
  - sclk_fall: 1→0 on synchronized sclk.
  - sync_fall / sync_rise: edges on synchronized sync.
  - Sync flops reset to 1 for sclk/sync and 0 for din.
- State IDLE: on sync_fall → SHIFT, with bit_cnt=0.
- State SHIFT, on each sclk_fall:
  - shreg <= {shreg[FRAME_BITS-2:0], din_s}; bit_cnt++.
  - When bit_cnt==FRAME_BITS-1 at that edge, commit next cycle: frame_word and fields load, frame_valid=1 for one cycle, state → WAIT_HI.
- State SHIFT, early abort: sync_rise with bit_cnt<FRAME_BITS → frame_err=1 for one cycle, state → IDLE. Outputs keep their old values.
- State WAIT_HI: further sclk_fall edges are ignored (no error). sync_rise → IDLE. A sync_fall cannot occur before sync_rise.
- Simultaneous sync_rise and sclk_fall in SHIFT:
  - If this is the final bit, the sclk edge is accepted and the frame commits (valid, no err).
  - Otherwise the abort wins and the sclk edge is discarded.
- Latency: frame_valid rises 4 clk cycles after the pin-level final SCLK falling edge (2 sync stages + edge detect + commit register).
- busy: registered from state; 1 in SHIFT and WAIT_HI.
- rst_n asserted mid-frame: immediate abort to reset values, no frame_err. After release, a frame already in progress is ignored until the next sync_fall.
- Inputs only; the block never drives the link.

Optional Feature:
- Macro: DAC_RX_FRAME_CNT_EN.
- When defined, adds two outputs, each wrapping at 2^16 and reset to 0:
  - frame_cnt[15:0]: increments on every frame_valid.
  - err_cnt[15:0]: increments on every frame_err.
- When undefined, neither port nor counter exists, and the module is otherwise identical.

Test Plan:
- All scenarios use a 100 ns clk period (#50 toggle) and a 400 ns SCLK period.
- Reset check: hold rst_n=0 for 100 ns → all outputs 0, busy=0.
- Single frame: send 16'h2ABC → frame_valid pulses once; frame_word=16'h2ABC, pd_mode=2'b10, data_out=12'hABC; busy goes low 3 clk after SYNC rises.
- Back-to-back: send 16'h0FFF, then 16'h0001 with SYNC high for 2 SCLK periods between → two valid pulses; data_out=12'hFFF then 12'h001; frame_err never asserts.
- Early abort: raise SYNC after 9 bits of 16'h1234 → frame_err pulses once, frame_word keeps its previous value, no frame_valid. The next full frame 16'h0555 is received correctly.
- Extra clocks: send 20 SCLK falls inside one SYNC low with first 16 bits 16'h3001 → exactly one frame_valid, frame_word=16'h3001, no error.
- Reset mid-frame plus counters (DAC_RX_FRAME_CNT_EN defined):
  - Assert rst_n low after bit 6 → no valid/err; frame_cnt=0.
  - Then run 3 good frames and 1 aborted frame → frame_cnt=3, err_cnt=1.
